// File: rtl/pc_sp_unit_pkg.sv
// Shared encodings and default vectors for the program-counter / stack-pointer unit.
package pc_sp_unit_pkg;

   // Next-PC source select
   localparam logic [2:0] PC_SEL_HOLD   = 3'b000;
   localparam logic [2:0] PC_SEL_INCR   = 3'b001;
   localparam logic [2:0] PC_SEL_BRANCH = 3'b010;
   localparam logic [2:0] PC_SEL_JUMP   = 3'b011;
   localparam logic [2:0] PC_SEL_JREG   = 3'b100;
   localparam logic [2:0] PC_SEL_CALL   = 3'b101;

   // Stack operation select
   localparam logic [1:0] SP_OP_NONE = 2'b00;
   localparam logic [1:0] SP_OP_PUSH = 2'b01;
   localparam logic [1:0] SP_OP_POP  = 2'b10;

   // Unit state
   typedef enum logic {
      PSU_RUN  = 1'b0,
      PSU_TRAP = 1'b1
   } psu_state_t;

   // Processor-wide address defaults (full 32-bit values, truncated by the user)
   localparam logic [31:0] INST_START_ADDR    = 32'h0000_1000;
   localparam logic [31:0] INIT_STACK_POINTER = 32'h03FF_FFFF;
   localparam logic [31:0] STACK_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_sp_unit_stack_guard.sv
// Combinational stack bookkeeping: full/empty detection, fault decode,
// next stack pointer, memory address for the stack access and current depth.
module stack_guard
   import pc_sp_unit_pkg::*;
#(
   parameter int unsigned             ADDR_WIDTH  = 26,
   parameter logic [ADDR_WIDTH-1:0]   SP_RESET    = ADDR_WIDTH'(INIT_STACK_POINTER),
   parameter int unsigned             STACK_DEPTH = 1024
) (
   input  logic [ADDR_WIDTH-1:0] sp,
   input  logic [1:0]            sp_op,
   output logic                  full,
   output logic                  empty,
   output logic                  fault,
   output logic                  op_ok,
   output logic [ADDR_WIDTH-1:0] sp_next,
   output logic [ADDR_WIDTH-1:0] stack_addr,
   output logic [ADDR_WIDTH-1:0] depth
);

   localparam logic [ADDR_WIDTH-1:0] ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] SP_FULL = SP_RESET - ADDR_WIDTH'(STACK_DEPTH);

   assign full  = (sp == SP_FULL);
   assign empty = (sp == SP_RESET);
   assign depth = SP_RESET - sp;

   // Decode the requested stack op into legality, fault and the resulting pointer
   always_comb begin
      fault      = 1'b0;
      op_ok      = 1'b0;
      sp_next    = sp;
      stack_addr = sp;
      case (sp_op)
         SP_OP_PUSH: begin
            if (full) begin
               fault = 1'b1;
            end else begin
               op_ok   = 1'b1;
               sp_next = sp - ONE;
            end
         end
         SP_OP_POP: begin
            stack_addr = sp + ONE;
            if (empty) begin
               fault = 1'b1;
            end else begin
               op_ok   = 1'b1;
               sp_next = sp + ONE;
            end
         end
         default: begin
            fault = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pc_sp_unit.sv
// Program counter and stack pointer with call/link, stack fault detection,
// sticky fault flags and a one-cycle trap that vectors the PC.
module pc_sp_unit
   import pc_sp_unit_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 26,
   parameter int unsigned           IMM_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] PC_RESET    = ADDR_WIDTH'(INST_START_ADDR),
   parameter logic [ADDR_WIDTH-1:0] SP_RESET    = ADDR_WIDTH'(INIT_STACK_POINTER),
   parameter int unsigned           STACK_DEPTH = 1024,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(STACK_TRAP_VECTOR)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PC_LOAD,
   input  logic [2:0]            PC_SEL,
   input  logic [IMM_WIDTH-1:0]  IMM,
   input  logic [ADDR_WIDTH-1:0] JADDR,
   input  logic [31:0]           RS_DATA,
   input  logic [1:0]            SP_OP,
   input  logic                  FAULT_CLR,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic [ADDR_WIDTH-1:0] LINK,
   output logic [ADDR_WIDTH-1:0] SP,
   output logic [ADDR_WIDTH-1:0] STACK_ADDR,
   output logic                  STACK_MEM_EN,
   output logic [ADDR_WIDTH-1:0] DEPTH,
   output logic                  STACK_OVF,
   output logic                  STACK_UNF,
   output logic                  TRAP
);

   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   psu_state_t            state_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] sp_r;
   logic                  ovf_r;
   logic                  unf_r;
   logic [ADDR_WIDTH-1:0] pc_next_s;
   logic [ADDR_WIDTH-1:0] sp_next_s;
   logic [ADDR_WIDTH-1:0] imm_ext_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  fault_s;
   logic                  op_ok_s;
   logic                  run_fault_s;
   logic                  unused_rs_s;

   // Only the low address bits of the register operand form a jump target
   assign unused_rs_s = &{1'b0, RS_DATA[31:ADDR_WIDTH]};

   assign imm_ext_s = {{(ADDR_WIDTH-IMM_WIDTH){IMM[IMM_WIDTH-1]}}, IMM};

   stack_guard #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SP_RESET    (SP_RESET),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_guard (
      .sp         (sp_r),
      .sp_op      (SP_OP),
      .full       (full_s),
      .empty      (empty_s),
      .fault      (fault_s),
      .op_ok      (op_ok_s),
      .sp_next    (sp_next_s),
      .stack_addr (STACK_ADDR),
      .depth      (DEPTH)
   );

   // A fault only counts while running; stack ops are ignored during the trap
   assign run_fault_s  = fault_s && (state_r == PSU_RUN) && !RST;
   assign STACK_MEM_EN = op_ok_s && (state_r == PSU_RUN) && !RST;

   assign PC        = pc_r;
   assign SP        = sp_r;
   assign LINK      = pc_r + ONE;
   assign STACK_OVF = ovf_r;
   assign STACK_UNF = unf_r;
   assign TRAP      = (state_r == PSU_TRAP);

   // Select the candidate next PC from the requested source
   always_comb begin
      pc_next_s = pc_r;
      case (PC_SEL)
         PC_SEL_INCR:   pc_next_s = pc_r + ONE;
         PC_SEL_BRANCH: pc_next_s = pc_r + ONE + imm_ext_s;
         PC_SEL_JUMP:   pc_next_s = JADDR;
         PC_SEL_JREG:   pc_next_s = RS_DATA[ADDR_WIDTH-1:0];
         PC_SEL_CALL:   pc_next_s = JADDR;
         default:       pc_next_s = pc_r;
      endcase
   end

   // Run/trap sequencing together with the PC and SP registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= PSU_RUN;
         pc_r    <= PC_RESET;
         sp_r    <= SP_RESET;
      end else begin
         case (state_r)
            PSU_RUN: begin
               if (fault_s) begin
                  state_r <= PSU_TRAP;
               end else begin
                  if (op_ok_s) begin
                     sp_r <= sp_next_s;
                  end
                  if (PC_LOAD) begin
                     pc_r <= pc_next_s;
                  end
               end
            end
            PSU_TRAP: begin
               pc_r    <= TRAP_VECTOR;
               state_r <= PSU_RUN;
            end
            default: begin
               state_r <= PSU_RUN;
            end
         endcase
      end
   end

   // Sticky fault flags: clear on request, but a fault in the same cycle wins
   always_ff @(posedge CLK) begin
      if (RST) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         ovf_r <= (ovf_r && !FAULT_CLR) || (run_fault_s && full_s && (SP_OP == SP_OP_PUSH));
         unf_r <= (unf_r && !FAULT_CLR) || (run_fault_s && empty_s && (SP_OP == SP_OP_POP));
      end
   end

endmodule

// File: doc/pc_sp_unit.md
# pc_sp_unit

Parametrised program-counter and stack-pointer unit for the cs147sec05 processor. It replaces the fixed 32-bit PC/SP register pair and next-PC mux chain in the data path. It adds:
- configurable address width and stack depth,
- a call/link path,
- stack overflow/underflow detection with sticky flags,
- a one-cycle trap sequence that vectors the PC on a stack fault.

The control unit drives it once per instruction. Its outputs feed the memory address mux and the register-file write-data mux.

## Interface
Parameters:
- ADDR_WIDTH, 26: width of PC, SP and all address outputs.
- IMM_WIDTH, 16: width of the branch immediate.
- PC_RESET, 'h0001000: PC value after reset.
- SP_RESET, 'h3FFFFFF: SP value after reset (stack empty).
- STACK_DEPTH, 1024: maximum number of stacked words. Must satisfy 1 ≤ STACK_DEPTH ≤ SP_RESET.
- TRAP_VECTOR, 'h0000080: PC value loaded on a stack fault.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- PC_LOAD  in  1  update PC this cycle according to PC_SEL.
- PC_SEL  in  3  next-PC source: 000 HOLD, 001 INCR, 010 BRANCH, 011 JUMP, 100 JREG, 101 CALL. 110 and 111 act as HOLD.
- IMM  in  IMM_WIDTH  signed branch offset.
- JADDR  in  ADDR_WIDTH  jump target.
- RS_DATA  in  32  register value for JREG; the low ADDR_WIDTH bits are used.
- SP_OP  in  2  00 none, 01 push, 10 pop, 11 none.
- FAULT_CLR  in  1  clears the sticky fault flags.
- PC  out  ADDR_WIDTH  current PC.
- LINK  out  ADDR_WIDTH  PC+1, combinational; this is the write data for CALL.
- SP  out  ADDR_WIDTH  current SP.
- STACK_ADDR  out  ADDR_WIDTH  data-memory address for the current stack op: SP for push, SP+1 for pop, SP otherwise.
- STACK_MEM_EN  out  1  the current SP_OP is legal and is being performed.
- DEPTH  out  ADDR_WIDTH  SP_RESET − SP, i.e. number of stacked words.
- STACK_OVF  out  1  sticky: a push was attempted while the stack was full.
- STACK_UNF  out  1  sticky: a pop was attempted while the stack was empty.
- TRAP  out  1  high during the TRAP state cycle.

## Operation
- **Stack model:** the stack grows downward.
  - Push: memory[SP] is written externally; SP ← SP−1.
  - Pop: SP ← SP+1; memory[SP+1] is read externally.
  - Empty: SP == SP_RESET. Full: SP == SP_RESET − STACK_DEPTH.
- **Next-PC values** (all arithmetic modulo 2^ADDR_WIDTH):
  - INCR: PC+1.
  - BRANCH: PC+1+sext(IMM).
  - JUMP: JADDR.
  - JREG: RS_DATA[ADDR_WIDTH−1:0].
  - CALL: JADDR, with LINK available to the register file.
- **FSM states:** RUN, TRAP.
  - **RUN:**
    - A legal SP_OP updates SP and asserts STACK_MEM_EN.
    - A PC_LOAD updates PC.
    - A fault is a push when full or a pop when empty. On a fault: SP is unchanged, STACK_MEM_EN = 0, the PC update is suppressed, the matching sticky flag is set, and next state is TRAP.
  - **TRAP** (exactly one cycle):
    - PC ← TRAP_VECTOR and TRAP = 1.
    - PC_LOAD and SP_OP are ignored; STACK_MEM_EN = 0.
    - Next state is RUN.
- **Sticky flags:** FAULT_CLR clears both flags. A fault in the same cycle as FAULT_CLR leaves its flag set (set wins).
- **Reset values:**
  - PC = PC_RESET, SP = SP_RESET, state = RUN.
  - STACK_OVF = STACK_UNF = TRAP = 0.
  - DEPTH = 0; STACK_MEM_EN = 0 while RST is high.
- RST asserted during TRAP aborts the trap: the next state is RUN with reset values, and no vector load occurs.

## Timing
- PC, SP, the flags and the state are registered.
- LINK, STACK_ADDR, STACK_MEM_EN and DEPTH are combinational from the current state and inputs.
- PC and SP update one edge after PC_LOAD/SP_OP are presented. A simultaneous PC_LOAD and legal SP_OP both take effect on the same edge.
- Fault latency:
  - The faulting cycle is edge N.
  - Flags are visible and TRAP = 1 after edge N.
  - PC = TRAP_VECTOR after edge N+1.
  - Normal operation resumes on inputs presented after edge N+1.
- Wrap-around: INCR from PC = 2^ADDR_WIDTH−1 gives 0. A branch offset below 0 wraps modulo 2^ADDR_WIDTH.

## Structure
- Add to prj_definition.v:
  - PC_SEL codes (PC_SEL_HOLD … PC_SEL_CALL).
  - SP_OP codes (SP_OP_NONE, SP_OP_PUSH, SP_OP_POP).
  - State encodings (PSU_RUN, PSU_TRAP).
  - Defaults equal to `INST_START_ADDR and `INIT_STACK_POINTER truncated to ADDR_WIDTH.
- One sub-module, stack_guard:
  - Parametrised by ADDR_WIDTH, SP_RESET and STACK_DEPTH.
  - Combinational.
  - From SP and SP_OP it produces: full, empty, fault, next SP, STACK_ADDR and DEPTH.
- The top level holds the PC/SP registers, the next-PC mux, the FSM and the sticky flags.

## Test plan
All scenarios use STACK_DEPTH=4, ADDR_WIDTH=26 and the default vectors.
- **Reset:** RST high for 2 cycles -> PC=0x0001000, SP=0x3FFFFFF, DEPTH=0, all flags 0, TRAP=0.
- **Increment and branch:** INCR from 0x0001000 -> 0x0001001. Then BRANCH with IMM=16'hFFFE -> PC=0x0001000. Then INCR from 0x3FFFFFF -> 0x0000000.
- **Call and jump-register:** CALL at PC=0x0001005 with JADDR=0x0002000 -> LINK=0x0001006 during the cycle, PC=0x0002000 next. Then JREG with RS_DATA=32'hFC001234 -> PC=0x0001234.
- **Push to overflow:**
  - 4 pushes -> SP=0x3FFFFFB, DEPTH=4, STACK_ADDR sequence 0x3FFFFFF…0x3FFFFFC.
  - 5th push with PC_LOAD INCR -> SP unchanged, PC unchanged, STACK_MEM_EN=0.
  - Then STACK_OVF=1 and TRAP=1 for one cycle, then PC=0x0000080.
- **Pop on empty:** pop after reset -> STACK_UNF=1, trap sequence as above. FAULT_CLR in the same cycle as a second empty pop -> STACK_UNF stays 1.
- **Reset mid-trap:** RST asserted in the TRAP cycle -> PC=0x0001000 (not 0x0000080), flags 0, state RUN.
